// File: rtl/nf2_dma_pkg.sv
// Shared field positions, request opcodes and scheduler state encoding for the
// CPCI DMA queue scheduler.
package nf2_dma_pkg;

  localparam int DW          = 32;
  localparam int REQ_FMT_BIT = DW + 3;
  localparam int EOP_RX_BIT  = DW + 2;
  localparam int BYTECNT_LSB = DW;
  localparam int QID_W       = 4;
  localparam int CNT_W       = 10;

  // In a request word the eop|rx bit selects the direction.
  typedef enum logic {
    OP_C2N = 1'b0,
    OP_N2C = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    C2N_DATA = 3'd1,
    DISCARD  = 3'd2,
    N2C_DATA = 3'd3,
    N2C_DROP = 3'd4
  } sched_state_e;

endpackage

// File: rtl/nf2_dma_sched_stats.sv
// Packet and error counters for the DMA queue scheduler; the module exists only
// when DMA_SCHED_STATS_EN is defined.
`ifdef DMA_SCHED_STATS_EN
module nf2_dma_sched_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        c2n_eop,
  input  logic        n2c_eop,
  input  logic        err,
  output logic [31:0] c2n_pkt_cnt,
  output logic [31:0] n2c_pkt_cnt,
  output logic [15:0] err_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c2n_pkt_cnt <= '0;
      n2c_pkt_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (c2n_eop) c2n_pkt_cnt <= c2n_pkt_cnt + 32'd1;
      if (n2c_eop) n2c_pkt_cnt <= n2c_pkt_cnt + 32'd1;
      if (err)     err_cnt     <= err_cnt + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/nf2_dma_queue_sched.sv
// Core-clock DMA sequencer: steers txfifo packets to CPU tx queues (C2N) and pulls
// CPU rx queue packets into rxfifo (N2C). DMA_SCHED_STATS_EN adds packet/error counters.
module nf2_dma_queue_sched
  import nf2_dma_pkg::*;
#(
  parameter int DMA_DATA_WIDTH = DW,
  parameter int NUM_CPU_QUEUES = 4,
  parameter int MAX_PKT_WORDS  = 512
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        txfifo_empty,
  output logic                                        txfifo_rd_en,
  input  logic [DMA_DATA_WIDTH+3:0]                   txfifo_rd_data,
  output logic [NUM_CPU_QUEUES-1:0]                   cpu_q_wr_en,
  output logic [DMA_DATA_WIDTH+2:0]                   cpu_q_wr_data,
  input  logic [NUM_CPU_QUEUES-1:0]                   cpu_q_nearly_full,
  input  logic [NUM_CPU_QUEUES-1:0]                   cpu_q_rd_empty,
  output logic [NUM_CPU_QUEUES-1:0]                   cpu_q_rd_en,
  input  logic [NUM_CPU_QUEUES*(DMA_DATA_WIDTH+3)-1:0] cpu_q_rd_data,
  input  logic                                        rxfifo_nearly_full,
  output logic                                        rxfifo_wr,
  output logic [DMA_DATA_WIDTH+2:0]                   rxfifo_wr_data,
  output logic                                        err_bad_qid,
  output logic                                        err_protocol,
  output logic [2:0]                                  state
`ifdef DMA_SCHED_STATS_EN
  ,
  output logic [31:0]                                 c2n_pkt_cnt,
  output logic [31:0]                                 n2c_pkt_cnt,
  output logic [15:0]                                 err_cnt
`endif
);

  // Package field positions are laid out for the default width; rebase them here.
  localparam int WW    = DMA_DATA_WIDTH + 3;
  localparam int REQ_B = REQ_FMT_BIT - DW + DMA_DATA_WIDTH;
  localparam int EOP_B = EOP_RX_BIT - DW + DMA_DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_WORDS - 1);

  sched_state_e               cur_state, nxt_state;
  logic [QID_W-1:0]           qid, qid_n;
  logic [CNT_W-1:0]           word_cnt, cnt_n;
  logic [NUM_CPU_QUEUES-1:0]  sel_oh;
  logic [WW-1:0]              q_word;
  logic                       sel_nf, sel_empty;
  logic                       req, tx_eop, qid_legal;
  logic [QID_W-1:0]           req_qid;
  op_e                        req_op;
  logic                       c2n_wr, rx_wr, force_eop, bad_qid, proto;

  assign req       = txfifo_rd_data[REQ_B];
  assign tx_eop    = txfifo_rd_data[EOP_B];
  assign req_op    = op_e'(tx_eop);
  assign req_qid   = txfifo_rd_data[QID_W-1:0];
  assign qid_legal = (int'(req_qid) < NUM_CPU_QUEUES);
  assign state     = cur_state;

  always_comb begin
    sel_oh = '0;
    q_word = '0;
    for (int i = 0; i < NUM_CPU_QUEUES; i++) begin
      if (qid == QID_W'(i)) begin
        sel_oh[i] = 1'b1;
        q_word    = cpu_q_rd_data[i*WW +: WW];
      end
    end
  end

  assign sel_nf    = |(cpu_q_nearly_full & sel_oh);
  assign sel_empty = ~|(~cpu_q_rd_empty & sel_oh);

  always_comb begin
    nxt_state    = cur_state;
    qid_n        = qid;
    cnt_n        = word_cnt;
    txfifo_rd_en = 1'b0;
    cpu_q_rd_en  = '0;
    c2n_wr       = 1'b0;
    rx_wr        = 1'b0;
    force_eop    = 1'b0;
    bad_qid      = 1'b0;
    proto        = 1'b0;
    // Pops are combinational, so they are held off explicitly while in reset.
    if (!reset) begin
      case (cur_state)
        IDLE: if (!txfifo_empty) begin
          txfifo_rd_en = 1'b1;
          if (req) begin
            qid_n = req_qid;
            if (!qid_legal) begin
              bad_qid = 1'b1;
              if (req_op == OP_C2N) nxt_state = DISCARD;
            end else if (req_op == OP_C2N) begin
              nxt_state = C2N_DATA;
            end else begin
              nxt_state = N2C_DATA;
              cnt_n     = '0;
            end
          end else begin
            proto = 1'b1;
          end
        end
        C2N_DATA: if (!txfifo_empty) begin
          // A new request leaves the FIFO untouched and is handled from IDLE.
          if (req) begin
            proto     = 1'b1;
            nxt_state = IDLE;
          end else if (!sel_nf) begin
            txfifo_rd_en = 1'b1;
            c2n_wr       = 1'b1;
            if (tx_eop) nxt_state = IDLE;
          end
        end
        DISCARD: if (!txfifo_empty) begin
          if (req) begin
            nxt_state = IDLE;
          end else begin
            txfifo_rd_en = 1'b1;
            if (tx_eop) nxt_state = IDLE;
          end
        end
        N2C_DATA: if (!sel_empty && !rxfifo_nearly_full) begin
          cpu_q_rd_en = sel_oh;
          rx_wr       = 1'b1;
          cnt_n       = (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);
          if (q_word[WW-1]) begin
            nxt_state = IDLE;
          end else if (word_cnt == LAST_CNT) begin
            force_eop = 1'b1;
            proto     = 1'b1;
            nxt_state = N2C_DROP;
          end
        end
        N2C_DROP: if (!sel_empty) begin
          cpu_q_rd_en = sel_oh;
          if (q_word[WW-1]) nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state      <= IDLE;
      qid            <= '0;
      word_cnt       <= '0;
      cpu_q_wr_en    <= '0;
      cpu_q_wr_data  <= '0;
      rxfifo_wr      <= 1'b0;
      rxfifo_wr_data <= '0;
      err_bad_qid    <= 1'b0;
      err_protocol   <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      qid          <= qid_n;
      word_cnt     <= cnt_n;
      cpu_q_wr_en  <= c2n_wr ? sel_oh : '0;
      if (c2n_wr) cpu_q_wr_data <= txfifo_rd_data[WW-1:0];
      rxfifo_wr    <= rx_wr;
      if (rx_wr) rxfifo_wr_data <= {q_word[WW-1] | force_eop, q_word[WW-2:0]};
      err_bad_qid  <= bad_qid;
      err_protocol <= proto;
    end
  end

`ifdef DMA_SCHED_STATS_EN
  nf2_dma_sched_stats u_stats (
    .clk         (clk),
    .reset       (reset),
    .c2n_eop     ((|cpu_q_wr_en) & cpu_q_wr_data[WW-1]),
    .n2c_eop     (rxfifo_wr & rxfifo_wr_data[WW-1]),
    .err         (err_bad_qid | err_protocol),
    .c2n_pkt_cnt (c2n_pkt_cnt),
    .n2c_pkt_cnt (n2c_pkt_cnt),
    .err_cnt     (err_cnt)
  );
`endif

endmodule

// File: tb/tb_nf2_dma_queue_sched.sv
// Self-checking bench for nf2_dma_queue_sched: FWFT FIFO models, a packet-level
// reference model and per-scenario scoreboard checks.
module tb_nf2_dma_queue_sched;
  import nf2_dma_pkg::*;

  localparam int DWD = 32;
  localparam int NQ  = 4;
  localparam int MAXW = 512;
  localparam int WW  = DWD + 3;
  localparam int TW  = DWD + 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              txfifo_empty;
  logic              txfifo_rd_en;
  logic [TW-1:0]     txfifo_rd_data;
  logic [NQ-1:0]     cpu_q_wr_en;
  logic [WW-1:0]     cpu_q_wr_data;
  logic [NQ-1:0]     cpu_q_nearly_full;
  logic [NQ-1:0]     cpu_q_rd_empty;
  logic [NQ-1:0]     cpu_q_rd_en;
  logic [NQ*WW-1:0]  cpu_q_rd_data;
  logic              rxfifo_nearly_full;
  logic              rxfifo_wr;
  logic [WW-1:0]     rxfifo_wr_data;
  logic              err_bad_qid;
  logic              err_protocol;
  logic [2:0]        dut_state;
`ifdef DMA_SCHED_STATS_EN
  logic [31:0]       c2n_pkt_cnt;
  logic [31:0]       n2c_pkt_cnt;
  logic [15:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  nf2_dma_queue_sched dut (
    .clk                (clk),
    .reset              (reset),
    .txfifo_empty       (txfifo_empty),
    .txfifo_rd_en       (txfifo_rd_en),
    .txfifo_rd_data     (txfifo_rd_data),
    .cpu_q_wr_en        (cpu_q_wr_en),
    .cpu_q_wr_data      (cpu_q_wr_data),
    .cpu_q_nearly_full  (cpu_q_nearly_full),
    .cpu_q_rd_empty     (cpu_q_rd_empty),
    .cpu_q_rd_en        (cpu_q_rd_en),
    .cpu_q_rd_data      (cpu_q_rd_data),
    .rxfifo_nearly_full (rxfifo_nearly_full),
    .rxfifo_wr          (rxfifo_wr),
    .rxfifo_wr_data     (rxfifo_wr_data),
    .err_bad_qid        (err_bad_qid),
    .err_protocol       (err_protocol),
    .state              (dut_state)
`ifdef DMA_SCHED_STATS_EN
    ,
    .c2n_pkt_cnt        (c2n_pkt_cnt),
    .n2c_pkt_cnt        (n2c_pkt_cnt),
    .err_cnt            (err_cnt)
`endif
  );

  // FIFO contents seen by the DUT, and the model's private copies.
  logic [TW-1:0] tx_q[$];
  logic [WW-1:0] cq[NQ][$];
  logic [TW-1:0] m_tx[$];
  logic [WW-1:0] m_cq[NQ][$];

  // Scoreboard: C2N entries are {qid, word}.
  logic [WW+3:0] exp_c2n[$];
  logic [WW+3:0] obs_c2n[$];
  logic [WW-1:0] exp_rx[$];
  logic [WW-1:0] obs_rx[$];
  int exp_bad, exp_proto, obs_bad, obs_proto;
  int stall_viol, pop_viol;
  int total = 0;
  int bad = 0;

  logic          rand_stall = 1'b0;
  logic          man_rx_nf = 1'b0;
  logic [NQ-1:0] man_q_nf = '0;
  logic          nf_prev_rx = 1'b0;
  logic [NQ-1:0] nf_prev_q = '0;

  task automatic refresh();
    txfifo_empty   = (tx_q.size() == 0);
    txfifo_rd_data = txfifo_empty ? '0 : tx_q[0];
    for (int i = 0; i < NQ; i++) begin
      cpu_q_rd_empty[i] = (cq[i].size() == 0);
      cpu_q_rd_data[i*WW +: WW] = cpu_q_rd_empty[i] ? '0 : cq[i][0];
    end
  endtask

  // FIFO owner: sample pops just before the edge takes effect, then advance the FIFOs.
  initial begin
    logic          tx_pop;
    logic [NQ-1:0] rd_pop;
    refresh();
    forever begin
      @(posedge clk);
      tx_pop     = txfifo_rd_en;
      rd_pop     = cpu_q_rd_en;
      nf_prev_rx = rxfifo_nearly_full;
      nf_prev_q  = cpu_q_nearly_full;
      #1;
      if ($countones(rd_pop) > 1) pop_viol++;
      if (tx_pop) begin
        if (tx_q.size() == 0) pop_viol++;
        else void'(tx_q.pop_front());
      end
      for (int i = 0; i < NQ; i++) begin
        if (rd_pop[i]) begin
          if (cq[i].size() == 0) pop_viol++;
          else void'(cq[i].pop_front());
        end
      end
      refresh();
    end
  end

  always @(negedge clk) begin
    if (rand_stall) begin
      cpu_q_nearly_full  = NQ'($urandom_range(0, (1 << NQ) - 1));
      rxfifo_nearly_full = ($urandom_range(0, 3) == 0);
    end else begin
      cpu_q_nearly_full  = man_q_nf;
      rxfifo_nearly_full = man_rx_nf;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if ($countones(cpu_q_wr_en) > 1) pop_viol++;
      for (int i = 0; i < NQ; i++) begin
        if (cpu_q_wr_en[i]) begin
          obs_c2n.push_back({4'(i), cpu_q_wr_data});
          if (nf_prev_q[i]) stall_viol++;
        end
      end
      if (rxfifo_wr) begin
        obs_rx.push_back(rxfifo_wr_data);
        if (nf_prev_rx) stall_viol++;
      end
      if (err_bad_qid) obs_bad++;
      if (err_protocol) obs_proto++;
    end
  end

  // ---------------- reference model (packet level) ----------------
  task automatic model_n2c(input int q);
    logic [WW-1:0] w;
    int  n = 0;
    bit  dropping = 0;
    while (m_cq[q].size() > 0) begin
      w = m_cq[q].pop_front();
      if (dropping) begin
        if (w[WW-1]) break;
      end else begin
        n++;
        if (w[WW-1]) begin
          exp_rx.push_back(w);
          break;
        end
        if (n == MAXW) begin
          w[WW-1] = 1'b1;
          exp_proto++;
          dropping = 1;
        end
        exp_rx.push_back(w);
      end
    end
  endtask

  task automatic model_run();
    int mode = 0;  // 0 waiting for request, 1 forwarding C2N, 2 discarding
    logic [3:0] q = '0;
    int i = 0;
    logic [TW-1:0] w;
    while (i < m_tx.size()) begin
      w = m_tx[i];
      if (w[TW-1] && mode == 1) begin exp_proto++; mode = 0; continue; end
      if (w[TW-1] && mode == 2) begin mode = 0; continue; end
      i++;
      if (mode == 0) begin
        if (!w[TW-1]) exp_proto++;
        else begin
          q = w[3:0];
          if (int'(q) >= NQ) begin
            exp_bad++;
            if (!w[WW-1]) mode = 2;
          end else if (!w[WW-1]) mode = 1;
          else model_n2c(int'(q));
        end
      end else if (mode == 1) begin
        exp_c2n.push_back({q, w[WW-1:0]});
        if (w[WW-1]) mode = 0;
      end else if (w[WW-1]) mode = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [TW-1:0] req_w(input logic op, input logic [3:0] q);
    logic [TW-1:0] w = '0;
    w[TW-1] = 1'b1;
    w[WW-1] = op;
    w[3:0]  = q;
    return w;
  endfunction

  function automatic logic [TW-1:0] dat_w(input logic eop, input logic [1:0] bc, input logic [31:0] d);
    return {1'b0, eop, bc, d};
  endfunction

  task automatic add_c2n(input int q, input int len, input bit term);
    m_tx.push_back(req_w(OP_C2N, 4'(q)));
    for (int i = 0; i < len; i++)
      m_tx.push_back(dat_w(term && (i == len - 1), 2'($urandom_range(0, 3)), $urandom()));
  endtask

  task automatic add_n2c(input int q, input int len);
    m_tx.push_back(req_w(OP_N2C, 4'(q)));
    for (int i = 0; i < len; i++)
      m_cq[q].push_back({(i == len - 1), 2'($urandom_range(0, 3)), 32'($urandom())});
  endtask

  task automatic clear_sb();
    exp_c2n.delete(); obs_c2n.delete(); exp_rx.delete(); obs_rx.delete();
    exp_bad = 0; exp_proto = 0; obs_bad = 0; obs_proto = 0;
    stall_viol = 0; pop_viol = 0;
  endtask

  task automatic launch();
    for (int i = 0; i < m_tx.size(); i++) tx_q.push_back(m_tx[i]);
    for (int q = 0; q < NQ; q++)
      for (int j = 0; j < m_cq[q].size(); j++) cq[q].push_back(m_cq[q][j]);
    model_run();
    m_tx.delete();
    for (int q = 0; q < NQ; q++) m_cq[q].delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && cq[0].size() == 0 && cq[1].size() == 0 && cq[2].size() == 0 &&
          cq[3].size() == 0 && dut_state == IDLE) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int diff_c2n();
    int d = (obs_c2n.size() != exp_c2n.size()) ? 1 : 0;
    for (int i = 0; i < obs_c2n.size() && i < exp_c2n.size(); i++)
      if (obs_c2n[i] !== exp_c2n[i]) d++;
    return d;
  endfunction

  function automatic int diff_rx();
    int d = (obs_rx.size() != exp_rx.size()) ? 1 : 0;
    for (int i = 0; i < obs_rx.size() && i < exp_rx.size(); i++)
      if (obs_rx[i] !== exp_rx[i]) d++;
    return d;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tx_q.push_back(req_w(OP_C2N, 4'd1));
    repeat (3) @(negedge clk);
    total++; if (txfifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", txfifo_rd_en); end
    total++; if ({cpu_q_wr_en, cpu_q_rd_en, rxfifo_wr, err_bad_qid, err_protocol} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {cpu_q_wr_en, cpu_q_rd_en, rxfifo_wr, err_bad_qid, err_protocol}); end
    total++; if ({cpu_q_wr_data, rxfifo_wr_data} !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {cpu_q_wr_data, rxfifo_wr_data}); end
    total++; if (dut_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut_state, IDLE); end
    tx_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_c2n();
    bit ok;
    logic [WW+3:0] last;
    clear_sb();
    m_tx.push_back(req_w(OP_C2N, 4'd2));
    m_tx.push_back(dat_w(1'b0, 2'd0, 32'h1111_0001));
    m_tx.push_back(dat_w(1'b0, 2'd0, 32'h1111_0002));
    m_tx.push_back(dat_w(1'b1, 2'd1, 32'h1111_0003));
    launch();
    wait_done(200, ok);
    last = (obs_c2n.size() == 3) ? obs_c2n[2] : 'x;
    total++; if (!ok) begin bad++; $display("FAIL c2n_done: timeout, state=%0d", dut_state); end
    total++; if (diff_c2n() !== 0) begin bad++; $display("FAIL c2n_seq: got %0d words (%0d differ) want %0d", obs_c2n.size(), diff_c2n(), exp_c2n.size()); end
    total++; if (last !== {4'd2, 1'b1, 2'd1, 32'h1111_0003}) begin bad++; $display("FAIL c2n_last: got %h want %h", last, {4'd2, 1'b1, 2'd1, 32'h1111_0003}); end
    total++; if (dut_state !== IDLE) begin bad++; $display("FAIL c2n_idle: got %0d want %0d", dut_state, IDLE); end
    // Random packets under random back-pressure.
    clear_sb();
    for (int k = 0; k < 6; k++) add_c2n($urandom_range(0, NQ - 1), $urandom_range(1, 6), 1);
    rand_stall = 1'b1;
    launch();
    wait_done(800, ok);
    rand_stall = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL c2n_rand_done: timeout, state=%0d", dut_state); end
    total++; if (diff_c2n() !== 0) begin bad++; $display("FAIL c2n_rand_seq: got %0d words (%0d differ) want %0d", obs_c2n.size(), diff_c2n(), exp_c2n.size()); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL c2n_stall: got %0d writes past nearly_full want 0", stall_viol); end
    total++; if (obs_proto !== 0 || obs_bad !== 0) begin bad++; $display("FAIL c2n_errs: got proto=%0d bad_qid=%0d want 0/0", obs_proto, obs_bad); end
  endtask

  task automatic test_n2c_stall();
    bit ok;
    clear_sb();
    add_n2c(1, 5);
    launch();
    for (int c = 0; c < 50 && obs_rx.size() < 2; c++) @(negedge clk);
    man_rx_nf = 1'b1;
    repeat (3) @(negedge clk);
    man_rx_nf = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL n2c_done: timeout, state=%0d", dut_state); end
    total++; if (diff_rx() !== 0) begin bad++; $display("FAIL n2c_seq: got %0d words (%0d differ) want %0d", obs_rx.size(), diff_rx(), exp_rx.size()); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL n2c_stall: got %0d writes past nearly_full want 0", stall_viol); end
    total++; if (pop_viol !== 0 || obs_c2n.size() !== 0) begin bad++; $display("FAIL n2c_pops: got pop_viol=%0d c2n=%0d want 0/0", pop_viol, obs_c2n.size()); end
  endtask

  task automatic test_bad_qid();
    bit ok;
    clear_sb();
    add_c2n(7, 4, 1);
    m_tx.push_back(req_w(OP_N2C, 4'd12));
    add_c2n(3, 2, 1);
    launch();
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL badq_done: timeout, state=%0d", dut_state); end
    total++; if (obs_bad !== exp_bad) begin bad++; $display("FAIL badq_pulses: got %0d want %0d", obs_bad, exp_bad); end
    total++; if (diff_c2n() !== 0) begin bad++; $display("FAIL badq_seq: got %0d words (%0d differ) want %0d", obs_c2n.size(), diff_c2n(), exp_c2n.size()); end
    total++; if (obs_proto !== exp_proto) begin bad++; $display("FAIL badq_proto: got %0d want %0d", obs_proto, exp_proto); end
  endtask

  task automatic test_protocol();
    bit ok;
    clear_sb();
    m_tx.push_back(dat_w(1'b1, 2'd0, 32'hDEAD_0001));
    add_c2n(0, 2, 0);
    add_n2c(2, 3);
    launch();
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL proto_done: timeout, state=%0d", dut_state); end
    total++; if (obs_proto !== exp_proto) begin bad++; $display("FAIL proto_pulses: got %0d want %0d", obs_proto, exp_proto); end
    total++; if (diff_c2n() !== 0 || diff_rx() !== 0) begin bad++; $display("FAIL proto_seq: got c2n=%0d rx=%0d want %0d/%0d", obs_c2n.size(), obs_rx.size(), exp_c2n.size(), exp_rx.size()); end
    // Random mix of legal, truncated, stray and bad-qid traffic.
    clear_sb();
    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 4))
        0: m_tx.push_back(dat_w(1'($urandom_range(0, 1)), 2'd0, $urandom()));
        1: add_c2n($urandom_range(0, NQ - 1), $urandom_range(1, 5), 1);
        2: add_c2n($urandom_range(0, NQ - 1), $urandom_range(1, 3), 0);
        3: add_n2c($urandom_range(0, NQ - 1), $urandom_range(1, 6));
        default: add_c2n($urandom_range(NQ, 15), $urandom_range(0, 3), 1);
      endcase
    end
    add_c2n($urandom_range(0, NQ - 1), 2, 1);
    rand_stall = 1'b1;
    launch();
    wait_done(2000, ok);
    rand_stall = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL mix_done: timeout, state=%0d", dut_state); end
    total++; if (diff_c2n() !== 0) begin bad++; $display("FAIL mix_c2n: got %0d words (%0d differ) want %0d", obs_c2n.size(), diff_c2n(), exp_c2n.size()); end
    total++; if (diff_rx() !== 0) begin bad++; $display("FAIL mix_rx: got %0d words (%0d differ) want %0d", obs_rx.size(), diff_rx(), exp_rx.size()); end
    total++; if (obs_proto !== exp_proto || obs_bad !== exp_bad) begin
      bad++; $display("FAIL mix_errs: got proto=%0d bad_qid=%0d want %0d/%0d", obs_proto, obs_bad, exp_proto, exp_bad); end
    total++; if (stall_viol !== 0 || pop_viol !== 0) begin bad++; $display("FAIL mix_flow: got stall=%0d pop=%0d want 0/0", stall_viol, pop_viol); end
  endtask

  task automatic test_oversize();
    bit ok;
    logic eop_512;
    clear_sb();
    add_n2c(0, 600);
    add_n2c(1, MAXW);
    add_n2c(3, 3);
    launch();
    wait_done(3000, ok);
    eop_512 = (obs_rx.size() > MAXW - 1) ? obs_rx[MAXW-1][WW-1] : 1'bx;
    total++; if (!ok) begin bad++; $display("FAIL big_done: timeout, state=%0d", dut_state); end
    total++; if (obs_rx.size() !== 2 * MAXW + 3) begin bad++; $display("FAIL big_count: got %0d want %0d", obs_rx.size(), 2 * MAXW + 3); end
    total++; if (eop_512 !== 1'b1) begin bad++; $display("FAIL big_eop: got %b want 1", eop_512); end
    total++; if (diff_rx() !== 0) begin bad++; $display("FAIL big_seq: %0d words differ, want 0", diff_rx()); end
    total++; if (obs_proto !== 1) begin bad++; $display("FAIL big_proto: got %0d want 1", obs_proto); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_sb();
    add_c2n(2, 6, 1);
    launch();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if ({txfifo_rd_en, cpu_q_wr_en, cpu_q_rd_en, rxfifo_wr, err_bad_qid, err_protocol} !== '0) begin
      bad++; $display("FAIL rst_mid_ctrl: got %b want 0", {txfifo_rd_en, cpu_q_wr_en, cpu_q_rd_en, rxfifo_wr, err_bad_qid, err_protocol}); end
    total++; if ({cpu_q_wr_data, rxfifo_wr_data} !== '0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", {cpu_q_wr_data, rxfifo_wr_data}); end
    total++; if (dut_state !== IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want %0d", dut_state, IDLE); end
    tx_q.delete();
    for (int q = 0; q < NQ; q++) cq[q].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_sb();
    add_c2n(1, 3, 1);
    add_n2c(3, 4);
    launch();
    wait_done(300, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_after_done: timeout, state=%0d", dut_state); end
    total++; if (diff_c2n() !== 0 || diff_rx() !== 0) begin bad++; $display("FAIL rst_after_seq: got c2n=%0d rx=%0d want %0d/%0d", obs_c2n.size(), obs_rx.size(), exp_c2n.size(), exp_rx.size()); end
  endtask

  initial begin
    reset = 1'b1;
    cpu_q_nearly_full  = '0;
    rxfifo_nearly_full = 1'b0;
    test_reset();
    test_c2n();
    test_n2c_stall();
    test_bad_qid();
    test_protocol();
    test_oversize();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
